// File: rtl/led_serial_dec.sv
// rtl/led_serial_dec.sv - nibble-serial LED-128 decryption core
// Serial load/unload of a 64-bit block; 48 inverse rounds with 13 key additions.
module led_serial_dec (
  input  logic clk,
  input  logic reset,
  input  logic keyi,
  input  logic datai,
  output logic dataq,
  input  logic loadkey,
  input  logic loadct,
  input  logic getpt,
  input  logic start,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE, INIT, INVMIX, INVSHIFT, INVSUB, NEXTROUND, ADDKEY, NEXTSTEP
  } ctl_t;

  ctl_t         ctlstate, ctl_n;
  logic [63:0]  state, state_n;
  logic [127:0] key, key_n;
  logic [5:0]   rc, rc_n;
  logic [3:0]   bcount, bcount_n, rcount, rcount_n, scount, scount_n;
  logic         rot, rot_n;

  function automatic logic [3:0] mul2(input logic [3:0] d);
    return {d[2], d[1], d[3] ^ d[0], d[3]};
  endfunction

  function automatic logic [3:0] mul_d(input logic [3:0] d);
    logic [3:0] d4;
    d4 = mul2(mul2(d));
    return mul2(d4) ^ d4 ^ d;
  endfunction

  function automatic logic [3:0] sinv(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  function automatic logic [3:0] rconst(input logic [3:0] b, input logic [5:0] r);
    case (b)
      4'd0:         return 4'h8;
      4'd4:         return 4'h9;
      4'd8:         return 4'h2;
      4'd12:        return 4'h3;
      4'd1, 4'd9:   return {1'b0, r[5:3]};
      4'd5, 4'd13:  return {1'b0, r[2:0]};
      default:      return 4'h0;
    endcase
  endfunction

  assign dataq = state[63];
  assign done  = (ctlstate == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctlstate <= IDLE;
      state    <= '0;
      key      <= '0;
      rc       <= 6'h04;
      bcount   <= '0;
      rcount   <= '0;
      scount   <= '0;
      rot      <= 1'b0;
    end else begin
      ctlstate <= ctl_n;
      state    <= state_n;
      key      <= key_n;
      rc       <= rc_n;
      bcount   <= bcount_n;
      rcount   <= rcount_n;
      scount   <= scount_n;
      rot      <= rot_n;
    end
  end

  always_comb begin
    ctl_n    = ctlstate;
    state_n  = state;
    key_n    = key;
    rc_n     = rc;
    bcount_n = bcount;
    rcount_n = rcount;
    scount_n = scount;
    rot_n    = rot;
    case (ctlstate)
      IDLE: begin
        rc_n     = 6'h04;
        bcount_n = '0;
        rcount_n = '0;
        scount_n = '0;
        rot_n    = 1'b0;
        if (loadkey)     key_n   = {key[126:0], keyi};
        else if (loadct) state_n = {state[62:0], datai};
        else if (getpt)  state_n = {state[62:0], 1'b0};
        if (start) ctl_n = INIT;
      end
      INIT, ADDKEY: begin
        state_n  = {state[59:0], state[63:60] ^ key[127:124]};
        key_n    = {key[123:0], key[127:124]};
        bcount_n = bcount + 4'd1;
        if (bcount == 4'd15) ctl_n = (ctlstate == INIT) ? INVMIX : NEXTSTEP;
      end
      INVMIX: begin
        // Four column steps, then a row rotate brings the next column to column 0.
        if (!rot) begin
          state_n[63:60] = mul_d(state[15:12] ^ state[63:60] ^ mul2(state[47:44]) ^ mul2(state[31:28]));
          state_n[47:44] = state[63:60];
          state_n[31:28] = state[47:44];
          state_n[15:12] = state[31:28];
          bcount_n = bcount + 4'd1;
          if (bcount[1:0] == 2'd3) rot_n = 1'b1;
        end else begin
          state_n = {state[59:48], state[63:60], state[43:32], state[47:44],
                     state[27:16], state[31:28], state[11:0],  state[15:12]};
          rot_n = 1'b0;
          if (bcount == 4'd0) ctl_n = INVSHIFT;
        end
      end
      INVSHIFT: begin
        state_n = {state[63:48],
                   state[35:32], state[47:36],
                   state[23:16], state[31:24],
                   state[11:0],  state[15:12]};
        ctl_n = INVSUB;
      end
      INVSUB: begin
        state_n  = {state[59:0], sinv(state[63:60]) ^ rconst(bcount, rc)};
        bcount_n = bcount + 4'd1;
        if (bcount == 4'd15) begin
          rc_n  = {1'b1 ^ rc[0] ^ rc[5], rc[5:1]};
          ctl_n = NEXTROUND;
        end
      end
      NEXTROUND: begin
        rcount_n = rcount + 4'd1;
        if (rcount == 4'd3) begin
          rcount_n = '0;
          ctl_n    = ADDKEY;
        end else begin
          ctl_n = INVMIX;
        end
      end
      NEXTSTEP: begin
        scount_n = scount + 4'd1;
        if (scount == 4'd11) begin
          scount_n = '0;
          ctl_n    = IDLE;
        end else begin
          ctl_n = INVMIX;
        end
      end
      default: ctl_n = IDLE;
    endcase
  end

endmodule
